// File: rtl/booth_adder_responder.sv
// booth_adder_responder: responder end of the booth Adder request/ack interface.
// It captures two operands on a request and adds them CHUNK bits per cycle.
// It then returns the sum and carry with a single-cycle ack.
//  CLK            in   clock, all state updates on posedge
//  RSTK           in   asynchronous active-low reset
//  Adder_datain1  in   operand A, latched in ADD_IDLE on Adder_valid
//  Adder_datain2  in   operand B, latched with A (pre-negated by initiator for subtract)
//  Adder_valid    in   level request, held by the initiator until ack
//  Adder_dataout  out  registered sum A+B mod 2^WIDTH
//  Adder_carryout out  registered carry-out (bit WIDTH of A+B)
//  Adder_ack      out  registered one-cycle acknowledge
module booth_adder_responder #(
    parameter int WIDTH = 25,
    parameter int CHUNK = 5
) (
    input  logic             CLK,
    input  logic             RSTK,
    input  logic [WIDTH-1:0] Adder_datain1,
    input  logic [WIDTH-1:0] Adder_datain2,
    input  logic             Adder_valid,
    output logic [WIDTH-1:0] Adder_dataout,
    output logic             Adder_carryout,
    output logic             Adder_ack
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("booth_adder_responder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {ADD_IDLE, ADD_COMPUTE, ADD_ACK, ADD_RELEASE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a, b, sum, sum_n;
    logic [CHUNK-1:0] chunk;
    logic [IW-1:0]    idx;
    logic             carry, carry_n, last;

    // One chunk of the ripple add; the final chunk's result is forwarded straight
    // into the output register so dataout updates exactly on the COMPUTE->ACK edge.
    always_comb begin
        {carry_n, chunk} = {1'b0, a[int'(idx)*CHUNK +: CHUNK]}
                         + {1'b0, b[int'(idx)*CHUNK +: CHUNK]}
                         + (CHUNK+1)'(carry);
        sum_n = sum;
        sum_n[int'(idx)*CHUNK +: CHUNK] = chunk;
        last = idx == IW'(NCHUNK - 1);
    end

    always_comb begin
        state_n = state;
        case (state)
            ADD_IDLE:    state_n = Adder_valid ? ADD_COMPUTE : ADD_IDLE;
            ADD_COMPUTE: state_n = last ? ADD_ACK : ADD_COMPUTE;
            ADD_ACK:     state_n = ADD_RELEASE;
            default:     state_n = Adder_valid ? ADD_RELEASE : ADD_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTK)
        if (!RSTK) state <= ADD_IDLE;
        else state <= state_n;

    always_ff @(posedge CLK or negedge RSTK)
        if (!RSTK) begin
            a              <= '0;
            b              <= '0;
            sum            <= '0;
            carry          <= 1'b0;
            idx            <= '0;
            Adder_dataout  <= '0;
            Adder_carryout <= 1'b0;
            Adder_ack      <= 1'b0;
        end else begin
            Adder_ack <= state == ADD_COMPUTE && last;
            if (state == ADD_IDLE && Adder_valid) begin
                a     <= Adder_datain1;
                b     <= Adder_datain2;
                carry <= 1'b0;
                idx   <= '0;
            end else if (state == ADD_COMPUTE) begin
                sum   <= sum_n;
                carry <= carry_n;
                idx   <= last ? '0 : idx + 1'b1;
                if (last) begin
                    Adder_dataout  <= sum_n;
                    Adder_carryout <= carry_n;
                end
            end
        end
endmodule

// File: tb/tb_booth_adder_responder.sv
// tb_booth_adder_responder: self-checking bench for booth_adder_responder.
// It covers the default 5x5-bit build (model-checked every cycle) and a single-chunk build.
module tb_booth_adder_responder;
    localparam int W = 25;
    localparam int N = 5;

    logic         CLK = 1'b0;
    logic         RSTK = 1'b0;
    logic [W-1:0] d1 = '0, d2 = '0;
    logic         v1 = 1'b0, v2 = 1'b0;
    logic [W-1:0] o1, o2;
    logic         c1, c2, k1, k2;

    int pass = 0;
    int total = 0;

    booth_adder_responder #(.WIDTH(W), .CHUNK(5)) dut (
        .CLK(CLK), .RSTK(RSTK), .Adder_datain1(d1), .Adder_datain2(d2),
        .Adder_valid(v1), .Adder_dataout(o1), .Adder_carryout(c1), .Adder_ack(k1)
    );

    booth_adder_responder #(.WIDTH(W), .CHUNK(W)) dut1 (
        .CLK(CLK), .RSTK(RSTK), .Adder_datain1(d1), .Adder_datain2(d2),
        .Adder_valid(v2), .Adder_dataout(o2), .Adder_carryout(c2), .Adder_ack(k2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: a request seen in idle completes N edges later with
    // (A+B) as a 26-bit value; ack follows for one cycle, then valid must drop.
    int           ph = 0, left = 0;
    logic [W-1:0] ma = '0, mb = '0, md = '0;
    logic         mc = 1'b0, mack = 1'b0;

    always @(posedge CLK or negedge RSTK)
        if (!RSTK) begin
            ph = 0; md = '0; mc = 1'b0; mack = 1'b0;
        end else begin
            mack = 1'b0;
            if (ph == 0 && v1) begin
                ma = d1; mb = d2; left = N; ph = 1;
            end else if (ph == 1) begin
                left--;
                if (left == 0) begin
                    {mc, md} = {1'b0, ma} + {1'b0, mb};
                    mack = 1'b1;
                    ph = 2;
                end
            end else if (ph == 2) ph = 3;
            else if (ph == 3 && !v1) ph = 0;
        end

    always @(negedge CLK) begin
        chk("ack", {31'b0, k1}, {31'b0, mack});
        chk("dataout", {7'b0, o1}, {7'b0, md});
        chk("carryout", {31'b0, c1}, {31'b0, mc});
    end

    task automatic req1(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        input bit toggle, output int lat);
        @(negedge CLK);
        d1 = a; d2 = b; v1 = 1'b1; lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (toggle) begin d1 = W'($urandom); d2 = W'($urandom); end
        end while (!k1 && lat < 20);
        if (!k1) chk("ack_timeout", 0, 1);
        if (hold) repeat (3) begin
            @(negedge CLK);
            chk("no_second_ack", {31'b0, k1}, 0);
        end
        v1 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic req2(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic [W:0] e;
        e = {1'b0, a} + {1'b0, b};
        @(negedge CLK);
        d1 = a; d2 = b; v2 = 1'b1; lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!k2 && lat < 20);
        chk("c25_latency", lat, 2);
        v2 = 1'b0;
        @(negedge CLK);
        chk("c25_dataout", {7'b0, o2}, {7'b0, e[W-1:0]});
        chk("c25_carry", {31'b0, c2}, {31'b0, e[W]});
    endtask

    task automatic dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic ec, input bit hold, input bit toggle);
        int lat;
        req1(a, b, hold, toggle, lat);
        chk({name, "_latency"}, lat, 6);
        chk({name, "_dataout"}, {7'b0, o1}, {7'b0, es});
        chk({name, "_carry"}, {31'b0, c1}, {31'b0, ec});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic [W:0] e;
        repeat (2) @(negedge CLK);
        chk("reset_dataout", {7'b0, o1}, 0);
        chk("reset_carry", {31'b0, c1}, 0);
        chk("reset_ack", {31'b0, k1}, 0);
        chk("reset_c25_dataout", {7'b0, o2}, 0);
        RSTK = 1'b1;

        dir("t1", 25'h0000001, 25'h0000002, 25'h0000003, 1'b0, 1'b0, 1'b0);
        dir("t2", 25'h1FFFFFF, 25'h0000001, 25'h0000000, 1'b1, 1'b0, 1'b0);
        dir("t3a", 25'h0000005, 25'h1FFFFFD, 25'h0000002, 1'b1, 1'b0, 1'b0);
        dir("t3b", 25'h0000003, 25'h1FFFFFB, 25'h1FFFFFE, 1'b0, 1'b0, 1'b0);
        dir("t4hold", 25'h0123456, 25'h0654321, 25'h0777777, 1'b0, 1'b1, 1'b0);
        dir("t4again", 25'h1000000, 25'h1000000, 25'h0000000, 1'b1, 1'b0, 1'b0);
        dir("t4toggle", 25'h0ABCDEF, 25'h0111111, 25'h0BCDF00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset pulse in the middle of a computation.
        @(negedge CLK);
        d1 = 25'h0000010; d2 = 25'h0000020; v1 = 1'b1;
        repeat (2) @(negedge CLK);
        #2 RSTK = 1'b0;
        #1;
        chk("rst_async_dataout", {7'b0, o1}, 0);
        chk("rst_async_carry", {31'b0, c1}, 0);
        chk("rst_async_ack", {31'b0, k1}, 0);
        v1 = 1'b0;
        #9 RSTK = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            chk("rst_no_ack", {31'b0, k1}, 0);
        end
        dir("t5after", 25'h0000007, 25'h0000008, 25'h000000F, 1'b0, 1'b0, 1'b0);

        req2(25'h0ABCDEF, 25'h1543210);
        chk("t6_literal", {7'b0, o2}, 32'h1FFFFFF);
        req2(25'h1FFFFFF, 25'h1FFFFFF);

        repeat (1000) begin
            ra = W'($urandom);
            rb = W'($urandom);
            e = {1'b0, ra} + {1'b0, rb};
            req1(ra, rb, 1'b0, $urandom_range(0, 1) == 1, lat);
            chk("rand_latency", lat, 6);
            chk("rand_sum", {6'b0, c1, o1}, {6'b0, e});
        end
        repeat (50) req2(W'($urandom), W'($urandom));

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
